// File: rtl/cv32e40p_ft_recovery_ctrl.sv
// Recovery sequencer for the triplicated FT wrappers: halts the pipeline, re-syncs a
// broken replica a bounded number of times, then retires it or escalates to fatal.
//
//   state  | meaning
//   IDLE   | no recovery in progress, pick lowest pending replica
//   HALT   | pipeline halt requested, waiting for ack (bounded)
//   RESYNC | one-cycle re-sync pulse to the victim wrapper
//   CHECK  | settle wait, then re-sample the victim's broken flag
//   FATAL  | majority lost or ack timed out; absorbing until reset
module cv32e40p_ft_recovery_ctrl #(
    parameter int unsigned N_BLK       = 4,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BLK-1:0]     err_detected_i,
    input  logic [N_BLK-1:0]     err_corrected_i,
    input  logic [3*N_BLK-1:0]   is_broken_i,
    output logic [3*N_BLK-1:0]   set_broken_o,
    output logic                 halt_req_o,
    input  logic                 halt_ack_i,
    output logic                 resync_o,
    output logic [3:0]           resync_blk_o,
    output logic                 fatal_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic [CNT_W-1:0]     corr_cnt_o
);

    localparam int unsigned NB = 3 * N_BLK;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HALT   = 3'd1,
        S_RESYNC = 3'd2,
        S_CHECK  = 3'd3,
        S_FATAL  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [NB-1:0]    brk_q;
    logic [NB-1:0]    pend_q, pend_d;
    logic [NB-1:0]    setb_q;
    logic [RW-1:0]    retry_q [NB];
    logic [IW-1:0]    victim_q;
    logic [3:0]       vblk_q;
    logic [1:0]       vrep_q;
    logic [SW-1:0]    settle_q;
    logic [TW-1:0]    tmo_q;
    logic [3:0]       blk_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] corr_cnt_q;

    logic [NB-1:0]    cap;
    logic [NB-1:0]    clr;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [3:0]       sel_blk;
    logic [1:0]       sel_rep;
    logic             brk_cur;
    logic [RW-1:0]    retry_cur;
    logic             retry_left;
    logic             settle_done;
    logic [2:0]       blk_bits;
    logic             maj_lost;

    // Edges on already-retired replicas are ignored.
    assign cap = is_broken_i & ~brk_q & ~setb_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_blk   = '0;
        sel_rep   = '0;
        for (int k = 0; k < int'(N_BLK); k++) begin
            for (int r = 0; r < 3; r++) begin
                if (pend_q[3*k+r] && !sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(3*k+r);
                    sel_blk   = 4'(k);
                    sel_rep   = 2'(r);
                end
            end
        end
    end

    always_comb begin
        clr = '0;
        if (state_q == S_IDLE && sel_found) begin
            clr[sel_idx] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | cap;
    end

    assign brk_cur     = is_broken_i[victim_q];
    assign retry_cur   = retry_q[victim_q];
    assign retry_left  = (retry_cur < RW'(MAX_RETRY));
    assign settle_done = (settle_q <= SW'(1));
    // Wrapper replica flags as they will be once the victim is retired.
    assign blk_bits    = setb_q[3*vblk_q +: 3] | (3'b001 << vrep_q);
    assign maj_lost    = (blk_bits[0] & blk_bits[1]) | (blk_bits[0] & blk_bits[2]) |
                         (blk_bits[1] & blk_bits[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) state_d = S_HALT;
            end
            S_HALT: begin
                if (halt_ack_i)         state_d = S_RESYNC;
                else if (tmo_q == '0)   state_d = S_FATAL;
            end
            S_RESYNC: state_d = S_CHECK;
            S_CHECK: begin
                if (settle_done) begin
                    if (!brk_cur)        state_d = S_IDLE;
                    else if (retry_left) state_d = S_RESYNC;
                    else if (maj_lost)   state_d = S_FATAL;
                    else                 state_d = S_IDLE;
                end
            end
            S_FATAL: state_d = S_FATAL;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        halt_req_o = 1'b0;
        resync_o   = 1'b0;
        fatal_o    = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            S_IDLE:   busy_o     = 1'b0;
            S_HALT:   halt_req_o = 1'b1;
            S_RESYNC: begin
                halt_req_o = 1'b1;
                resync_o   = 1'b1;
            end
            S_CHECK:  halt_req_o = 1'b1;
            S_FATAL: begin
                halt_req_o = 1'b1;
                fatal_o    = 1'b1;
            end
            default:  busy_o     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q    <= '0;
            pend_q   <= '0;
            setb_q   <= '0;
            victim_q <= '0;
            vblk_q   <= '0;
            vrep_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            blk_q    <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                retry_q[i] <= '0;
            end
        end else begin
            brk_q  <= is_broken_i;
            pend_q <= pend_d;
            if (state_d == S_RESYNC) begin
                blk_q <= vblk_q;
            end
            case (state_q)
                S_IDLE: begin
                    tmo_q <= TW'(ACK_TIMEOUT - 1);
                    if (sel_found) begin
                        victim_q <= sel_idx;
                        vblk_q   <= sel_blk;
                        vrep_q   <= sel_rep;
                    end
                end
                S_HALT: begin
                    if (tmo_q != '0) tmo_q <= tmo_q - 1'b1;
                end
                S_RESYNC: begin
                    retry_q[victim_q] <= retry_cur + 1'b1;
                    settle_q          <= SW'(SETTLE_CYC);
                end
                S_CHECK: begin
                    if (!settle_done) begin
                        settle_q <= settle_q - 1'b1;
                    end else if (!brk_cur) begin
                        retry_q[victim_q] <= '0;
                    end else if (!retry_left) begin
                        setb_q[victim_q]  <= 1'b1;
                        retry_q[victim_q] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            corr_cnt_q <= '0;
        end else begin
            if ((|err_detected_i) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if ((|err_corrected_i) && (corr_cnt_q != '1)) begin
                corr_cnt_q <= corr_cnt_q + 1'b1;
            end
        end
    end

    assign set_broken_o = setb_q;
    assign resync_blk_o = blk_q;
    assign err_cnt_o    = err_cnt_q;
    assign corr_cnt_o   = corr_cnt_q;

endmodule
